// File: rtl/pwm_peripheral.sv
// pwm_peripheral: drives 16 pins low, high, or with a shared 8-bit PWM waveform.
// Optional macro PWM_DUTY_SHADOW_EN: duty is latched at period wrap instead of used live.
module pwm_peripheral #(
  parameter int PRESCALE = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_cnt_q, presc_cnt_d;
  logic [7:0]    pwm_cnt_q, pwm_cnt_d;
  logic [15:0]   out_q, out_d;
  logic          period_start_q, period_start_d;
  logic [15:0]   en_out, en_pwm;
  logic [7:0]    duty_ref;
  logic          tick, wrap, pwm_level;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  assign tick = (presc_cnt_q == PRESC_MAX);
  assign wrap = tick && (pwm_cnt_q == 8'hFF);

`ifdef PWM_DUTY_SHADOW_EN
  logic [7:0] duty_q, duty_d;

  assign duty_d   = wrap ? pwm_duty_cycle : duty_q;
  assign duty_ref = duty_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) duty_q <= 8'h00;
    else        duty_q <= duty_d;
  end
`else
  assign duty_ref = pwm_duty_cycle;
`endif

  // 0xFF is continuous high rather than 255/256 of the period
  assign pwm_level = (duty_ref == 8'hFF) || (pwm_cnt_q < duty_ref);

  always_comb begin
    presc_cnt_d    = tick ? '0 : presc_cnt_q + PW'(1);
    pwm_cnt_d      = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    out_d          = en_out & (~en_pwm | {16{pwm_level}});
    period_start_d = wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt_q    <= '0;
      pwm_cnt_q      <= 8'h00;
      out_q          <= 16'h0000;
      period_start_q <= 1'b0;
    end else begin
      presc_cnt_q    <= presc_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      out_q          <= out_d;
      period_start_q <= period_start_d;
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Testbench for pwm_peripheral: two instances (PRESCALE 13 and 1) share stimulus;
// a cycle scoreboard plus period/high-time measurements check the outputs.
module tb_pwm_peripheral;

  localparam int P0 = 13;
  localparam int P1 = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  eo_lo = 8'h00, eo_hi = 8'h00, ep_lo = 8'h00, ep_hi = 8'h00, duty = 8'h00;
  logic [15:0] out0, out1;
  logic        ps0, ps1;

  always #5 clk = ~clk;

  pwm_peripheral #(.PRESCALE(P0)) dut (
    .clk(clk), .rst_n(rst_n),
    .en_reg_out_7_0(eo_lo), .en_reg_out_15_8(eo_hi),
    .en_reg_pwm_7_0(ep_lo), .en_reg_pwm_15_8(ep_hi),
    .pwm_duty_cycle(duty), .out(out0), .period_start(ps0)
  );

  pwm_peripheral #(.PRESCALE(P1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .en_reg_out_7_0(eo_lo), .en_reg_out_15_8(eo_hi),
    .en_reg_pwm_7_0(ep_lo), .en_reg_pwm_15_8(ep_hi),
    .pwm_duty_cycle(duty), .out(out1), .period_start(ps1)
  );

  typedef struct packed {
    logic [15:0] o;
    logic        ps;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   failures = 0;
  int   t0 = 0, t1 = 0;
  logic [7:0] sh0 = 8'h00, sh1 = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: time since reset gives the counter position directly.
  function automatic exp_t model(input int t, input int p, input logic [7:0] d,
                                 input logic [15:0] eo, input logic [15:0] ep);
    exp_t e;
    int   cnt;
    logic lvl;
    cnt  = (t / p) % 256;
    lvl  = (d == 8'hFF) || (cnt < int'({24'd0, d}));
    e.o  = (eo & ~ep) | (eo & ep & {16{lvl}});
    e.ps = ((t % p) == p - 1) && (cnt == 255);
    return e;
  endfunction

  function automatic bit is_wrap(input int t, input int p);
    return ((t % p) == p - 1) && (((t / p) % 256) == 255);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      t0 = 0; t1 = 0; sh0 = 8'h00; sh1 = 8'h00;
      q0.delete(); q1.delete();
    end else begin
`ifdef PWM_DUTY_SHADOW_EN
      q0.push_back(model(t0, P0, sh0, {eo_hi, eo_lo}, {ep_hi, ep_lo}));
      q1.push_back(model(t1, P1, sh1, {eo_hi, eo_lo}, {ep_hi, ep_lo}));
`else
      q0.push_back(model(t0, P0, duty, {eo_hi, eo_lo}, {ep_hi, ep_lo}));
      q1.push_back(model(t1, P1, duty, {eo_hi, eo_lo}, {ep_hi, ep_lo}));
`endif
      if (is_wrap(t0, P0)) sh0 = duty;
      if (is_wrap(t1, P1)) sh1 = duty;
      t0++; t1++;
    end
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("sb_out_p13", {16'd0, out0}, {16'd0, e.o});
      chk("sb_ps_p13", {31'd0, ps0}, {31'd0, e.ps});
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("sb_out_p1", {16'd0, out1}, {16'd0, e.o});
      chk("sb_ps_p1", {31'd0, ps1}, {31'd0, e.ps});
    end
  end

  task automatic set_in(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
    {eo_hi, eo_lo} = eo;
    {ep_hi, ep_lo} = ep;
    duty = d;
  endtask

  // Aligns to a period_start (sampled at negedge) then counts one full period.
  task automatic measure(input bit sel, output int len, output int high);
    int guard;
    guard = 0; len = 0; high = 0;
    while (!(sel ? ps1 : ps0) && guard < 8000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 8000) begin
      chk("period_start_timeout", 32'd1, 32'd0);
      return;
    end
    do begin
      high += int'(sel ? out1[0] : out0[0]);
      len++;
      @(negedge clk);
    end while (!(sel ? ps1 : ps0) && len < 8000);
  endtask

  initial begin
    int len, high, exp_h1;

    // Reset held with random inputs
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      set_in(16'($urandom), 16'($urandom), 8'($urandom));
      chk("rst_out_p13", {16'd0, out0}, 32'd0);
      chk("rst_ps_p13", {31'd0, ps0}, 32'd0);
      chk("rst_out_p1", {16'd0, out1}, 32'd0);
    end
    set_in(16'h00FF, 16'h0000, 8'h00);
    rst_n = 1'b1;

    @(negedge clk);
    chk("static_00ff", {16'd0, out0}, 32'h0000_00FF);
    set_in(16'hFFFF, 16'h0000, 8'h00);
    @(negedge clk);
    chk("static_ffff", {16'd0, out0}, 32'h0000_FFFF);
    set_in(16'hFFFF, 16'hFFFF, 8'h00);
    @(negedge clk);
    chk("pwm_duty0_all", {16'd0, out0}, 32'h0000_0000);

    // Random phase long enough to cross period wraps of both instances
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      set_in(16'($urandom), 16'($urandom), 8'($urandom));
    end

    // Asynchronous reset mid-period
    @(negedge clk);
    set_in(16'hFFFF, 16'h0000, 8'h00);
    @(negedge clk);
    chk("pre_async_rst", {16'd0, out0}, 32'h0000_FFFF);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out", {16'd0, out0}, 32'd0);
    chk("async_rst_out_p1", {16'd0, out1}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // First period_start exactly 256*PRESCALE cycles after release
    len = 0;
    while (!ps0 && len < 8000) begin
      @(negedge clk);
      len++;
    end
    chk("first_ps_delay", 32'(len), 32'(256 * P0));

    // Ratio at duty 0x80
    set_in(16'h0001, 16'h0001, 8'h80);
    @(negedge clk);
    measure(1'b0, len, high);
    measure(1'b0, len, high);
    chk("ratio_period", 32'(len), 32'(256 * P0));
    chk("ratio_high", 32'(high), 32'(128 * P0));

    set_in(16'h0001, 16'h0001, 8'h00);
    @(negedge clk);
    measure(1'b0, len, high);
    measure(1'b0, len, high);
    chk("duty00_high", 32'(high), 32'd0);

    set_in(16'h0001, 16'h0001, 8'hFF);
    @(negedge clk);
    measure(1'b0, len, high);
    measure(1'b0, len, high);
    chk("dutyff_high", 32'(high), 32'(256 * P0));
    chk("dutyff_period", 32'(len), 32'(256 * P0));

    // Duty change to 0xC0 at pwm_cnt 0x50 of a 0x40 period
    set_in(16'h0001, 16'h0001, 8'h40);
    @(negedge clk);
    measure(1'b0, len, high);
    measure(1'b0, len, high);
    high = 0;
    for (int n = 0; n < 256 * P0; n++) begin
      high += int'(out0[0]);
      if (n == 16'h50 * P0) duty = 8'hC0;
      if (n == 16'h50 * P0 + 1) begin
`ifdef PWM_DUTY_SHADOW_EN
        chk("shadow_no_rise", {31'd0, out0[0]}, 32'd0);
`else
        chk("live_rise", {31'd0, out0[0]}, 32'd1);
`endif
      end
      @(negedge clk);
    end
`ifdef PWM_DUTY_SHADOW_EN
    exp_h1 = 16'h40 * P0;
`else
    exp_h1 = 16'h40 * P0 + (16'hC0 - 16'h50) * P0;
`endif
    chk("change_period_high", 32'(high), 32'(exp_h1));
    measure(1'b0, len, high);
    chk("next_period_high", 32'(high), 32'(16'hC0 * P0));

    // PRESCALE = 1 instance
    set_in(16'h0001, 16'h0001, 8'h03);
    @(negedge clk);
    measure(1'b1, len, high);
    measure(1'b1, len, high);
    chk("p1_period", 32'(len), 32'd256);
    chk("p1_high", 32'(high), 32'd3);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
